// File: rtl/hangman_status_tx_pkg.sv
// rtl/hangman_status_tx_pkg.sv - shared hangman frame constants, types and byte packing
package hangman_pkg;

  localparam logic [7:0] HANG_SYNC        = 8'h7E;
  localparam int         HANG_FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_t;

  typedef struct packed {
    logic [7:0] letter;
    logic [4:0] index_mask;
    logic [2:0] correct;
    logic [2:0] incorrect;
    logic       win;
    logic       lose;
  } hang_snap_t;

  // Payload bytes B1..B3 packed as {B3, B2, B1}; the receive decoder unpacks the same layout.
  function automatic logic [23:0] hang_pack(input hang_snap_t s);
    return {{2'b00, s.incorrect, s.correct},
            {s.win, s.lose, 1'b0, s.index_mask},
            s.letter};
  endfunction

endpackage

// File: rtl/hangman_status_tx_if.sv
// rtl/hangman_status_tx_if.sv - guess-result inputs and serial status outputs of the status transmitter
interface hangman_status_tx_if;

  logic       update;
  logic [7:0] letter;
  logic [4:0] index_mask;
  logic [2:0] correct;
  logic [2:0] incorrect;
  logic       win;
  logic       lose;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output update, letter, index_mask, correct, incorrect, win, lose,
    input  tx, busy, done
  );

  modport slave (
    input  update, letter, index_mask, correct, incorrect, win, lose,
    output tx, busy, done
  );

endinterface

// File: rtl/hangman_status_tx_uart_tx_byte.sv
// rtl/hangman_status_tx_uart_tx_byte.sv - single-byte 8N1 serializer with load/ready handshake
module uart_tx_byte
  import hangman_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int            TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap  = (timer == LAST);
  // Ready in the last stop-bit cycle lets the next byte's start bit follow with no gap.
  assign ready = (state == IDLE) || ((state == STOP_BIT) && wrap);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      if (state != IDLE) begin
        timer <= wrap ? '0 : timer + TW'(1);
      end
      case (state)
        IDLE: begin
          if (load) begin
            state <= START_BIT;
            shreg <= data;
            timer <= '0;
            tx    <= 1'b0;
          end
        end
        START_BIT: begin
          if (wrap) begin
            state   <= DATA_BITS;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        DATA_BITS: begin
          if (wrap) begin
            if (bit_idx == 3'd7) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        STOP_BIT: begin
          if (wrap) begin
            if (load) begin
              state <= START_BIT;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/hangman_status_tx.sv
// rtl/hangman_status_tx.sv - snapshots each guess result and sends it as a 5-byte 8N1 status frame
module hangman_status_tx
  import hangman_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input logic                 clk,
  input logic                 Rst,
  hangman_status_tx_if.slave  bus
);

  hang_snap_t  in_snap;
  hang_snap_t  cur;
  hang_snap_t  pend;
  logic        pend_valid;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  byte_idx;

  logic        ser_ready;
  logic        ser_load;
  logic        ser_tx;
  logic [7:0]  ser_data;
  logic [23:0] payload;
  logic [7:0]  checksum;
  logic [7:0]  next_byte;
  logic        frame_end;
  logic        advance;
  logic        start_idle;
  logic        start_next;

  assign in_snap  = {bus.letter, bus.index_mask, bus.correct, bus.incorrect, bus.win, bus.lose};
  assign payload  = hang_pack(cur);
  assign checksum = payload[7:0] ^ payload[15:8] ^ payload[23:16];

  // The serializer only reports ready mid-frame in the final stop-bit cycle of a byte.
  assign frame_end  = busy_q && ser_ready && (byte_idx == 3'(HANG_FRAME_BYTES - 1));
  assign advance    = busy_q && ser_ready && !frame_end;
  assign start_idle = !busy_q && bus.update;
  assign start_next = frame_end && (pend_valid || bus.update);

  always_comb begin
    next_byte = checksum;
    case (byte_idx)
      3'd0:    next_byte = payload[7:0];
      3'd1:    next_byte = payload[15:8];
      3'd2:    next_byte = payload[23:16];
      default: next_byte = checksum;
    endcase
  end

  assign ser_load = start_idle || start_next || advance;
  assign ser_data = (start_idle || start_next) ? HANG_SYNC : next_byte;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      cur        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_idx   <= '0;
    end else begin
      done_q <= frame_end;
      if (start_idle) begin
        cur      <= in_snap;
        busy_q   <= 1'b1;
        byte_idx <= '0;
      end else if (start_next) begin
        // An update coinciding with frame end is newer than any held pending snapshot.
        cur        <= bus.update ? in_snap : pend;
        pend_valid <= 1'b0;
        byte_idx   <= '0;
      end else if (frame_end) begin
        busy_q   <= 1'b0;
        byte_idx <= '0;
      end else begin
        if (advance) begin
          byte_idx <= byte_idx + 3'd1;
        end
        if (busy_q && bus.update) begin
          pend       <= in_snap;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk   (clk),
    .Rst   (Rst),
    .load  (ser_load),
    .data  (ser_data),
    .ready (ser_ready),
    .tx    (ser_tx)
  );

  assign bus.tx   = ser_tx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/hangman_status_tx.md
# hangman_status_tx

Serializes the outcome of each evaluated guess from the game-logic block back to the player's handset over a UART-style 8N1 link. On an `update` strobe it snapshots the guessed letter, the per-position hit mask, the running correct/incorrect counts and the win/lose flags. It then transmits them as a fixed 5-byte frame. It sits between the game logic and the wireless/serial transmit pin, and is the return path for the guess receiver.

## Interface
- `CLKS_PER_BIT`, default 1042: clock cycles per serial bit; minimum 2. Counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`  in  1  system clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `update`  in  1  single-cycle request to send the current inputs.
- `letter`  in  8  ASCII of the evaluated guess.
- `index_mask`  in  5  per-position hit mask; bit 0 is the first letter.
- `correct`  in  3  correct-guess count, 0–5.
- `incorrect`  in  3  mistake count, 0–6.
- `win`  in  1  game won.
- `lose`  in  1  game lost.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while a frame is being shifted out.
- `done`  out  1  one-cycle pulse after the last stop bit of a frame.

## Operation
- Frame bytes, sent in order 0..4:
  - B0 = 0x7E (sync).
  - B1 = `letter`.
  - B2 = {`win`, `lose`, 1'b0, `index_mask`}.
  - B3 = {2'b00, `incorrect`, `correct`}.
  - B4 = B1^B2^B3 (checksum).
- Each byte is sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - Counters: a bit-timer (0..CLKS_PER_BIT-1), a bit index (0..7) and a byte index (0..4).
  - START_BIT→DATA_BITS→STOP_BIT each advance when the bit-timer wraps.
  - DATA_BITS advances after bit 7.
  - STOP_BIT goes to START_BIT of the next byte, or ends the frame after byte 4.
- Snapshot: all inputs are captured on the `update` edge. Later input changes do not affect a frame in flight.
- One-deep pending buffer:
  - `update` while `busy` stores a pending snapshot and sets a pending flag.
  - A further `update` overwrites the pending snapshot; only the newest is kept.
- Frame end:
  - If pending is set, the pending snapshot is loaded and the next frame starts with no idle bit; pending is cleared.
  - Otherwise the block returns to IDLE.
- `update` in the same cycle as frame end is treated as pending, so the next frame starts back-to-back.
- `win` and `lose` are sent as given; the block does not check their consistency.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0. Pending flag cleared, FSM in IDLE, all counters 0.
- `Rst` mid-frame takes effect immediately (asynchronous): `tx` returns high, and any partial frame and pending snapshot are discarded.
- With `update` high in cycle k while IDLE:
  - `busy` is 1 and `tx` is 0 from cycle k+1.
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - The frame occupies cycles k+1 .. k+50·CLKS_PER_BIT.
- `done` is 1 in cycle k+50·CLKS_PER_BIT+1 only.
  - In that cycle `busy`=0 if no frame is pending.
  - If a frame is pending, `busy` stays 1 and `tx`=0 (start bit of the next frame).
- `update` while IDLE has a latency of 1 cycle to the start bit.

## Structure
- Shared `hangman_pkg`:
  - `HANG_SYNC` = 8'h7E.
  - `HANG_FRAME_BYTES` = 5.
  - `tx_state_t` enum.
  - Frame byte-packing function, reused by the receive-side decoder.
- One sub-module, `uart_tx_byte`:
  - Single-byte 8N1 serializer with a `load`/`ready` handshake, parameterized by CLKS_PER_BIT.
- The top level holds the snapshot registers, the pending buffer, the byte sequencer and checksum generation.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert `Rst` → `tx`=1, `busy`=0, `done`=0. Hold idle 20 cycles → `tx` stays 1.
- Basic frame:
  - Stimulus: `letter`=0x41, `index_mask`=5'b00101, `correct`=2, `incorrect`=1, `win`=`lose`=0, `update` pulse.
  - Required: decoded bytes 7E,41,05,0A,4E, LSB first.
  - Required: each bit exactly 4 cycles; `done` at update+201.
- Win frame:
  - Stimulus: `letter`=0x5A, `index_mask`=5'h1F, `correct`=5, `incorrect`=0, `win`=1.
  - Required: bytes 7E,5A,9F,05,C0.
- Pending overwrite:
  - Stimulus: frame A in flight; `update` with letter 0x42, then `update` with letter 0x43.
  - Required: A completes, then a frame with B1=0x43 follows with no idle gap.
  - Required: `done` pulses twice; 0x42 is never sent.
- Reset mid-frame:
  - Stimulus: `Rst` during byte 2.
  - Required: `tx`=1 and `busy`=0 in the same cycle.
  - Required: the next `update` yields a full frame starting at 7E, with no leftover pending frame.
- Coincident event: `update` in the cycle before `done` → `tx`=0 in the `done` cycle, `busy` never drops, and the second frame is correct.
